// File: rtl/extram_bram_responder_pkg.sv
// Shared types and constants for the external-memory BRAM responder.
// The optional statistics counters are enabled with the EXTRAM_STATS_EN macro.
package extram_pkg;

  localparam int EXTRAM_WORD_W = 32;
  localparam int EXTRAM_LANES  = 4;

  localparam logic [3:0] EXTRAM_BASE_NIBBLE = 4'h1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } extram_state_t;

endpackage

// File: rtl/extram_bram_responder_if.sv
// Plasma external-memory port bundle between the CPU (master) and the responder (slave).
import extram_pkg::*;

interface extram_bram_responder_if;

  // Protocol:
  // - The master presents address/byte_we/data_write and holds them stable while mem_pause_out is high.
  // - The access completes in the first cycle with mem_pause_out low.
  // - data_read is valid in that cycle for reads.
  // - byte_we == 0 means read.
  logic [31:2]                 address;
  logic [EXTRAM_LANES-1:0]     byte_we;
  logic [EXTRAM_WORD_W-1:0]    data_write;
  logic [EXTRAM_WORD_W-1:0]    data_read;
  logic                        mem_pause_out;

  modport master (
    output address, byte_we, data_write,
    input  data_read, mem_pause_out
  );

  modport slave (
    input  address, byte_we, data_write,
    output data_read, mem_pause_out
  );

endinterface

// File: rtl/extram_bram_responder_bram.sv
// Single-port synchronous-read RAM with byte-lane write enables (read-first), BRAM-inferable.
import extram_pkg::*;

module extram_bram #(
  parameter int ADDR_BITS = 12
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic [EXTRAM_LANES-1:0]   we,
  input  logic [ADDR_BITS-1:0]      addr,
  input  logic [EXTRAM_WORD_W-1:0]  wdata,
  output logic [EXTRAM_WORD_W-1:0]  rdata
);

  logic [EXTRAM_WORD_W-1:0] mem [0:(1 << ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < EXTRAM_LANES; i++) begin
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/extram_bram_responder.sv
// Configurable-latency BRAM slave for the Plasma external-memory port; stalls the CPU via mem_pause_out.
// Define EXTRAM_STATS_EN to build the saturating read/write completion counters.
import extram_pkg::*;

module extram_bram_responder #(
  parameter int         ADDR_BITS   = 12,
  parameter logic [3:0] BASE_NIBBLE = EXTRAM_BASE_NIBBLE,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  extram_bram_responder_if.slave   bus,
  input  logic                     no_ddr_start,
  input  logic                     no_ddr_stop,
  output logic [15:0]              stat_reads,
  output logic [15:0]              stat_writes,
  output extram_state_t            state_dbg
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  extram_state_t             state;
  logic [3:0]                cnt;
  logic                      bypass;
  logic                      is_write;
  logic [EXTRAM_WORD_W-1:0]  data_q;
  logic [EXTRAM_WORD_W-1:0]  ram_rdata;
  logic                      hit;
  logic                      issue;
  logic                      unused_alias_bits;

  assign hit   = !reset && !bypass && (bus.address[31:28] == BASE_NIBBLE);
  assign issue = hit && (state == IDLE);

  // Address bits between the RAM index and the select nibble are don't-care: the window aliases.
  assign unused_alias_bits = ^bus.address[27:ADDR_BITS+2];

  extram_bram #(.ADDR_BITS(ADDR_BITS)) u_bram (
    .clk   (clk),
    .en    (issue),
    .we    (issue ? bus.byte_we : '0),
    .addr  (bus.address[ADDR_BITS+1:2]),
    .wdata (bus.data_write),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bypass   <= 1'b0;
      is_write <= 1'b0;
      data_q   <= '0;
    end else begin
      if (no_ddr_stop)       bypass <= 1'b0;
      else if (no_ddr_start) bypass <= 1'b1;

      case (state)
        IDLE: begin
          if (hit) begin
            is_write <= |bus.byte_we;
            cnt      <= CNT_LOAD;
            // The IDLE cycle is itself the first pause cycle, so a one-cycle wait skips WAIT.
            state    <= (CNT_LOAD == 4'd0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          if (!is_write) data_q <= ram_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM output register already holds the word in DONE; data_q keeps it afterwards.
  assign bus.data_read     = ((state == DONE) && !is_write) ? ram_rdata : data_q;
  assign bus.mem_pause_out = hit && (state != DONE);
  assign state_dbg         = state;

`ifdef EXTRAM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else if (state == DONE) begin
      if (is_write) begin
        if (stat_writes != 16'hFFFF) stat_writes <= stat_writes + 16'd1;
      end else begin
        if (stat_reads != 16'hFFFF) stat_reads <= stat_reads + 16'd1;
      end
    end
  end
`else
  assign stat_reads  = '0;
  assign stat_writes = '0;
`endif

endmodule

// File: tb/tb_extram_bram_responder.sv
// Directed plus randomized bench for extram_bram_responder against a word-array reference model.
import extram_pkg::*;

module tb_extram_bram_responder;

  localparam int WC = 2;
  localparam int AB = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          no_ddr_start;
  logic          no_ddr_stop;
  logic [15:0]   stat_reads;
  logic [15:0]   stat_writes;
  extram_state_t state_dbg;

  extram_bram_responder_if bus ();

  extram_bram_responder #(
    .ADDR_BITS   (AB),
    .BASE_NIBBLE (4'h1),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .no_ddr_start (no_ddr_start),
    .no_ddr_stop  (no_ddr_stop),
    .stat_reads   (stat_reads),
    .stat_writes  (stat_writes),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [int];
  int          keys[$];
  logic [31:0] last_read_m = '0;
  int          reads_m  = 0;
  int          writes_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[AB+1:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic chk_stats(input string tag);
`ifdef EXTRAM_STATS_EN
    chk({tag, "_reads"},  {16'd0, stat_reads},  32'(reads_m));
    chk({tag, "_writes"}, {16'd0, stat_writes}, 32'(writes_m));
`else
    chk({tag, "_reads"},  {16'd0, stat_reads},  32'd0);
    chk({tag, "_writes"}, {16'd0, stat_writes}, 32'd0);
`endif
  endtask

  // Called just after a rising edge; returns just after the edge that ends the DONE cycle.
  task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        input bit hold);
    logic [31:0] exp_rd;
    int          i;
    i = idx_of(a);
    bus.address    = a[31:2];
    bus.byte_we    = we;
    bus.data_write = wd;
    exp_rd = (we == 4'd0) ? mem_m[i] : last_read_m;
    for (int k = 0; k < WC; k++) begin
      @(negedge clk);
      chk($sformatf("pause_hi_%0d", k), {31'd0, bus.mem_pause_out}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pause_done", {31'd0, bus.mem_pause_out}, 32'd0);
    chk("state_done", 32'(state_dbg), 32'(DONE));
    chk("data_done", bus.data_read, exp_rd);
    if (we != 4'd0) begin
      mem_m[i] = merge(mem_m.exists(i) ? mem_m[i] : 32'd0, wd, we);
      writes_m++;
    end else begin
      last_read_m = exp_rd;
      reads_m++;
    end
    @(posedge clk); #1;
    chk_stats("stats");
    if (!hold) begin
      bus.address = '0;
      bus.byte_we = '0;
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({tag, "_pause"}, {31'd0, bus.mem_pause_out}, 32'd0);
      chk({tag, "_data"}, bus.data_read, last_read_m);
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[31:28]   = 4'h1;
    a[AB+1:2]  = idx[AB-1:0];
    a[1:0]     = 2'b00;
    return a;
  endfunction

  initial begin
    reset          = 1'b1;
    no_ddr_start   = 1'b0;
    no_ddr_stop    = 1'b0;
    bus.address    = 30'h0400_0004;
    bus.byte_we    = '0;
    bus.data_write = '0;

    // Reset: hit address presented, pause masked.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pause", {31'd0, bus.mem_pause_out}, 32'd0);
    @(posedge clk); #1;
    reset       = 1'b0;
    bus.address = '0;
    @(negedge clk);
    chk("reset_state", 32'(state_dbg), 32'(IDLE));
    chk("reset_data", bus.data_read, 32'd0);
    chk_stats("reset_stats");
    @(posedge clk); #1;

    // Full write then read back; partial lane write merges.
    access(32'h1000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0);
    access(32'h1000_0010, 4'h0, 32'h0, 1'b0);
    chk("full_const", bus.data_read, 32'hDEAD_BEEF);
    access(32'h1000_0010, 4'b0010, 32'h0000_AB00, 1'b0);
    access(32'h1000_0010, 4'h0, 32'h0, 1'b0);
    chk("partial_const", bus.data_read, 32'hDEAD_ABEF);

    // Non-hit address: no pause, data held, no write.
    bus.address = 30'h0800_0000;
    bus.byte_we = 4'hF;
    bus.data_write = 32'h5555_5555;
    idle_cycles("nohit", 3);

    // Bypass: hits are ignored, including writes.
    bus.address = '0;
    bus.byte_we = '0;
    no_ddr_start = 1'b1;
    @(posedge clk); #1;
    no_ddr_start = 1'b0;
    bus.address = 32'h1000_0010 >> 2;
    bus.byte_we = 4'hF;
    bus.data_write = 32'h1234_5678;
    idle_cycles("bypass", 3);
    bus.address = '0;
    bus.byte_we = '0;
    no_ddr_stop = 1'b1;
    @(posedge clk); #1;
    no_ddr_stop = 1'b0;
    access(32'h1000_0010, 4'h0, 32'h0, 1'b0);

    // Start and stop together: stop wins.
    no_ddr_start = 1'b1;
    @(posedge clk); #1;
    no_ddr_stop = 1'b1;
    @(posedge clk); #1;
    no_ddr_start = 1'b0;
    no_ddr_stop  = 1'b0;
    access(32'h1000_0010, 4'h0, 32'h0, 1'b0);

    // Back-to-back reads of the same address: two separate windows.
    access(32'h1000_0010, 4'h0, 32'h0, 1'b1);
    access(32'h1000_0010, 4'h0, 32'h0, 1'b0);

    // Reset in the second pause cycle: write already committed, no stats, data cleared.
    bus.address    = 32'h1000_0040 >> 2;
    bus.byte_we    = 4'hF;
    bus.data_write = 32'hCAFE_F00D;
    @(negedge clk);
    chk("abort_pause_idle", {31'd0, bus.mem_pause_out}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_pause_rst", {31'd0, bus.mem_pause_out}, 32'd0);
    @(posedge clk); #1;
    chk("abort_state", 32'(state_dbg), 32'(IDLE));
    chk("abort_data", bus.data_read, 32'd0);
    reset       = 1'b0;
    bus.address = '0;
    bus.byte_we = '0;
    mem_m[idx_of(32'h1000_0040)] = 32'hCAFE_F00D;
    last_read_m = '0;
    reads_m  = 0;
    writes_m = 0;
    chk_stats("abort_stats");
    access(32'h1000_0040, 4'h0, 32'h0, 1'b0);
    keys.push_back(idx_of(32'h1000_0010));
    keys.push_back(idx_of(32'h1000_0040));

    // Randomized writes/reads through aliased addresses.
    for (int n = 0; n < 24; n++) begin
      int          ix;
      logic [3:0]  we;
      case ($urandom_range(0, 2))
        0: begin
          ix = $urandom_range(0, (1 << AB) - 1);
          if (!mem_m.exists(ix)) keys.push_back(ix);
          access(rand_addr(ix), 4'hF, $urandom, 1'b0);
        end
        1: begin
          ix = keys[$urandom_range(0, keys.size() - 1)];
          we = 4'($urandom_range(1, 15));
          access(rand_addr(ix), we, $urandom, 1'b0);
        end
        default: begin
          ix = keys[$urandom_range(0, keys.size() - 1)];
          access(rand_addr(ix), 4'h0, 32'h0, 1'b0);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle_cycles("gap", 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
